// File: rtl/tile_axil_initiator_if.sv
// Command/response and AXI-Lite master channels of tile_axil_initiator.
// The master modport is the initiator's view; slave is the command source and AXI target side.
interface tile_axil_initiator_if #(
  parameter int BW       = 32,
  parameter int BWB      = BW / 8,
  parameter int AXI_ADDR = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [AXI_ADDR-1:0] cmd_addr;
  logic [BW-1:0]       cmd_wdata;
  logic [BWB-1:0]      cmd_wstrb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [BW-1:0]       rsp_rdata;
  logic [1:0]          rsp_resp;

  logic [AXI_ADDR-1:0] control_M_AXI_AWADDR;
  logic                control_M_AXI_AWVALID;
  logic                control_M_AXI_AWREADY;
  logic [BW-1:0]       control_M_AXI_WDATA;
  logic [BWB-1:0]      control_M_AXI_WSTRB;
  logic                control_M_AXI_WVALID;
  logic                control_M_AXI_WREADY;
  logic [1:0]          control_M_AXI_BRESP;
  logic                control_M_AXI_BVALID;
  logic                control_M_AXI_BREADY;
  logic [AXI_ADDR-1:0] control_M_AXI_ARADDR;
  logic                control_M_AXI_ARVALID;
  logic                control_M_AXI_ARREADY;
  logic [BW-1:0]       control_M_AXI_RDATA;
  logic [1:0]          control_M_AXI_RRESP;
  logic                control_M_AXI_RVALID;
  logic                control_M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output control_M_AXI_AWADDR, control_M_AXI_AWVALID,
    output control_M_AXI_WDATA, control_M_AXI_WSTRB, control_M_AXI_WVALID,
    output control_M_AXI_BREADY,
    output control_M_AXI_ARADDR, control_M_AXI_ARVALID,
    output control_M_AXI_RREADY,
    input  control_M_AXI_AWREADY, control_M_AXI_WREADY,
    input  control_M_AXI_BRESP, control_M_AXI_BVALID,
    input  control_M_AXI_ARREADY,
    input  control_M_AXI_RDATA, control_M_AXI_RRESP, control_M_AXI_RVALID
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  control_M_AXI_AWADDR, control_M_AXI_AWVALID,
    input  control_M_AXI_WDATA, control_M_AXI_WSTRB, control_M_AXI_WVALID,
    input  control_M_AXI_BREADY,
    input  control_M_AXI_ARADDR, control_M_AXI_ARVALID,
    input  control_M_AXI_RREADY,
    output control_M_AXI_AWREADY, control_M_AXI_WREADY,
    output control_M_AXI_BRESP, control_M_AXI_BVALID,
    output control_M_AXI_ARREADY,
    output control_M_AXI_RDATA, control_M_AXI_RRESP, control_M_AXI_RVALID
  );
endinterface

// File: rtl/tile_axil_initiator.sv
// Single-outstanding AXI-Lite initiator: turns one command into one AXI-Lite transaction and one response.
// Optional watchdog compiled in with `define TILE_AXIL_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module tile_axil_initiator #(
  parameter int BW             = 32,
  parameter int BWB            = BW / 8,
  parameter int AXI_ADDR       = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_control,
  input  logic                  clk_control_rst_high,
  tile_axil_initiator_if.master bus,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [AXI_ADDR-1:0] addr_q;
  logic [BW-1:0]       wdata_q;
  logic [BWB-1:0]      wstrb_q;
  logic [BW-1:0]       rdata_q;
  logic [1:0]          resp_q;
  logic                aw_done;
  logic                w_done;

  logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic busy;
  logic tmo_take;

  assign busy     = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                    (state == RD_ADDR) || (state == RD_DATA);
  assign cmd_fire = bus.cmd_valid && (state == IDLE);
  assign aw_fire  = aw_valid && bus.control_M_AXI_AWREADY;
  assign w_fire   = w_valid && bus.control_M_AXI_WREADY;
  assign b_fire   = b_ready && bus.control_M_AXI_BVALID;
  assign ar_fire  = ar_valid && bus.control_M_AXI_ARREADY;
  assign r_fire   = r_ready && bus.control_M_AXI_RVALID;

`ifdef TILE_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          tmo_flag;

  // A B/R handshake landing on the limit cycle still wins, so real slave data is never thrown away.
  assign tmo_hit  = busy && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign tmo_take = tmo_hit && !b_fire && !r_fire;

  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (cmd_fire)
        tmo_cnt <= '0;
      else if (busy && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_take)
        tmo_flag <= 1'b1;
    end
  end

  assign timeout_err = tmo_flag;
`else
  assign tmo_take    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (bus.cmd_valid) state_next = bus.cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
      WR_RESP:      if (b_fire) state_next = RESP;
      RD_ADDR:      if (ar_fire) state_next = RD_DATA;
      RD_DATA:      if (r_fire) state_next = RESP;
      RESP:         if (bus.rsp_ready) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
    if (tmo_take)
      state_next = RESP;
  end

  // AW and W each drop the cycle after their own handshake, tracked by the done flags.
  always_comb begin
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    case (state)
      WR_ADDR_DATA: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
      end
      WR_RESP: b_ready  = 1'b1;
      RD_ADDR: ar_valid = 1'b1;
      RD_DATA: r_ready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= 2'b00;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        wstrb_q <= bus.cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire)
        aw_done <= 1'b1;
      if (w_fire)
        w_done <= 1'b1;
      if (tmo_take) begin
        rdata_q <= '0;
        resp_q  <= 2'b11;
      end else if (b_fire) begin
        rdata_q <= '0;
        resp_q  <= bus.control_M_AXI_BRESP;
      end else if (r_fire) begin
        rdata_q <= bus.control_M_AXI_RDATA;
        resp_q  <= bus.control_M_AXI_RRESP;
      end
    end
  end

  assign bus.cmd_ready             = (state == IDLE);
  assign bus.rsp_valid             = (state == RESP);
  assign bus.rsp_rdata             = rdata_q;
  assign bus.rsp_resp              = resp_q;
  assign bus.control_M_AXI_AWADDR  = addr_q;
  assign bus.control_M_AXI_AWVALID = aw_valid;
  assign bus.control_M_AXI_WDATA   = wdata_q;
  assign bus.control_M_AXI_WSTRB   = wstrb_q;
  assign bus.control_M_AXI_WVALID  = w_valid;
  assign bus.control_M_AXI_BREADY  = b_ready;
  assign bus.control_M_AXI_ARADDR  = addr_q;
  assign bus.control_M_AXI_ARVALID = ar_valid;
  assign bus.control_M_AXI_RREADY  = r_ready;

endmodule

// File: tb/tb_tile_axil_initiator.sv
// Bench for tile_axil_initiator: directed commands against a configurable AXI-Lite slave model,
// with a response scoreboard popped by an independent monitor.
module tb_tile_axil_initiator;

  localparam int BW  = 32;
  localparam int BWB = 4;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout_err;

  always #5 clk = ~clk;

  tile_axil_initiator_if #(.BW(BW), .BWB(BWB), .AXI_ADDR(AW)) bus ();

  tile_axil_initiator #(
    .BW(BW), .BWB(BWB), .AXI_ADDR(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_control          (clk),
    .clk_control_rst_high (rst),
    .bus                  (bus.master),
    .timeout_err          (timeout_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   rsp_count = 0;
  int   b_count   = 0;

  int          aw_wait  = 0;
  int          w_wait   = 0;
  int          ar_wait  = 0;
  int          r_wait   = 0;
  bit          ar_never = 1'b0;
  logic [1:0]  bresp_val = 2'b00;
  logic [1:0]  rresp_val = 2'b00;
  logic [31:0] rdata_val = 32'h0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: READY after a programmable number of VALID cycles, B/R issued after both/address handshakes.
  initial begin : slave_model
    int aw_cnt, w_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, ar_got, aw_f, w_f, b_f, ar_f, r_f;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
    bus.control_M_AXI_AWREADY = 1'b0;
    bus.control_M_AXI_WREADY  = 1'b0;
    bus.control_M_AXI_ARREADY = 1'b0;
    bus.control_M_AXI_BVALID  = 1'b0;
    bus.control_M_AXI_BRESP   = 2'b00;
    bus.control_M_AXI_RVALID  = 1'b0;
    bus.control_M_AXI_RDATA   = 32'h0;
    bus.control_M_AXI_RRESP   = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.control_M_AXI_AWREADY = 1'b0;
        bus.control_M_AXI_WREADY  = 1'b0;
        bus.control_M_AXI_ARREADY = 1'b0;
        bus.control_M_AXI_BVALID  = 1'b0;
        bus.control_M_AXI_RVALID  = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
      end else begin
        if (aw_f) aw_got = 1;
        if (w_f)  w_got  = 1;
        if (ar_f) ar_got = 1;
        if (b_f)  bus.control_M_AXI_BVALID = 1'b0;
        if (r_f)  bus.control_M_AXI_RVALID = 1'b0;
        if (bus.control_M_AXI_AWVALID) begin
          bus.control_M_AXI_AWREADY = (aw_cnt >= aw_wait); aw_cnt++;
        end else begin
          bus.control_M_AXI_AWREADY = 1'b0; aw_cnt = 0;
        end
        if (bus.control_M_AXI_WVALID) begin
          bus.control_M_AXI_WREADY = (w_cnt >= w_wait); w_cnt++;
        end else begin
          bus.control_M_AXI_WREADY = 1'b0; w_cnt = 0;
        end
        if (bus.control_M_AXI_ARVALID) begin
          bus.control_M_AXI_ARREADY = !ar_never && (ar_cnt >= ar_wait); ar_cnt++;
        end else begin
          bus.control_M_AXI_ARREADY = 1'b0; ar_cnt = 0;
        end
        if (aw_got && w_got) begin
          bus.control_M_AXI_BVALID = 1'b1;
          bus.control_M_AXI_BRESP  = bresp_val;
          aw_got = 0; w_got = 0;
        end
        if (ar_got) begin
          r_cnt++;
          if (r_cnt > r_wait) begin
            bus.control_M_AXI_RVALID = 1'b1;
            bus.control_M_AXI_RDATA  = rdata_val;
            bus.control_M_AXI_RRESP  = rresp_val;
            ar_got = 0; r_cnt = 0;
          end
        end
        aw_f = bus.control_M_AXI_AWVALID && bus.control_M_AXI_AWREADY;
        w_f  = bus.control_M_AXI_WVALID && bus.control_M_AXI_WREADY;
        b_f  = bus.control_M_AXI_BVALID && bus.control_M_AXI_BREADY;
        ar_f = bus.control_M_AXI_ARVALID && bus.control_M_AXI_ARREADY;
        r_f  = bus.control_M_AXI_RVALID && bus.control_M_AXI_RREADY;
      end
    end
  end

  // Monitor: every completed response is checked against the oldest expected entry.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (!rst) begin
      if (bus.control_M_AXI_BVALID && bus.control_M_AXI_BREADY)
        b_count++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got rdata 0x%0h resp %0d, expected no response",
                   bus.rsp_rdata, bus.rsp_resp);
        end else begin
          e = exp_q.pop_front();
          check_output("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          check_output("rsp_resp", 64'(bus.rsp_resp), 64'(e.resp));
        end
        rsp_count++;
      end
    end
  end

  task automatic wait_cmd_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
  endtask

  // Returns one ns after the acceptance edge, i.e. at the start of cycle 1.
  task automatic apply_stimulus(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input bit expect_rsp,
                                input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
    rsp_t e;
    wait_cmd_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
    if (expect_rsp) begin
      e.rdata = exp_rdata;
      e.resp  = exp_resp;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_response(input int start);
    int n;
    n = 0;
    while (rsp_count == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("rsp_wait", 64'(rsp_count - start), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int start;
    int b_start;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_output("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_output("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("rst_awvalid", 64'(bus.control_M_AXI_AWVALID), 64'd0);
    check_output("rst_arvalid", 64'(bus.control_M_AXI_ARVALID), 64'd0);
    check_output("rst_bready", 64'(bus.control_M_AXI_BREADY), 64'd0);
    check_output("rst_rready", 64'(bus.control_M_AXI_RREADY), 64'd0);
    check_output("rst_awaddr", 64'(bus.control_M_AXI_AWADDR), 64'd0);
    check_output("rst_wdata", 64'(bus.control_M_AXI_WDATA), 64'd0);
    check_output("rst_wstrb", 64'(bus.control_M_AXI_WSTRB), 64'd0);
    check_output("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_output("rst_timeout_err", 64'(timeout_err), 64'd0);
    rst = 1'b0;

    $display("[TB] zero-wait write");
    start = rsp_count;
    apply_stimulus(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 2'b00);
    @(negedge clk);
    check_output("wr1_c1_awvalid", 64'(bus.control_M_AXI_AWVALID), 64'd1);
    check_output("wr1_c1_wvalid", 64'(bus.control_M_AXI_WVALID), 64'd1);
    check_output("wr1_c1_awaddr", 64'(bus.control_M_AXI_AWADDR), 64'h10);
    check_output("wr1_c1_wdata", 64'(bus.control_M_AXI_WDATA), 64'hDEADBEEF);
    check_output("wr1_c1_wstrb", 64'(bus.control_M_AXI_WSTRB), 64'hF);
    check_output("wr1_c1_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    check_output("wr1_c2_bready", 64'(bus.control_M_AXI_BREADY), 64'd1);
    check_output("wr1_c2_awvalid", 64'(bus.control_M_AXI_AWVALID), 64'd0);
    check_output("wr1_c2_wvalid", 64'(bus.control_M_AXI_WVALID), 64'd0);
    @(negedge clk);
    check_output("wr1_c3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    wait_response(start);

    $display("[TB] read with AR and R wait states");
    ar_wait = 2; r_wait = 5; rdata_val = 32'h12345678; rresp_val = 2'b00;
    start = rsp_count;
    apply_stimulus(1'b0, 8'h04, 32'h0, 4'h0, 1'b1, 32'h12345678, 2'b00);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_output("rd_arvalid_held", 64'(bus.control_M_AXI_ARVALID), 64'd1);
      check_output("rd_araddr", 64'(bus.control_M_AXI_ARADDR), 64'h04);
    end
    @(negedge clk);
    check_output("rd_arvalid_drop", 64'(bus.control_M_AXI_ARVALID), 64'd0);
    check_output("rd_rready", 64'(bus.control_M_AXI_RREADY), 64'd1);
    wait_response(start);
    ar_wait = 0; r_wait = 0;

    $display("[TB] write with W ahead of AW, zero strobe");
    aw_wait = 3; w_wait = 0;
    start = rsp_count;
    b_start = b_count;
    apply_stimulus(1'b1, 8'h20, 32'hA5A50000, 4'h0, 1'b1, 32'h0, 2'b00);
    @(negedge clk);
    check_output("wr3_c1_wstrb_zero", 64'(bus.control_M_AXI_WSTRB), 64'h0);
    @(negedge clk);
    check_output("wr3_c2_wvalid", 64'(bus.control_M_AXI_WVALID), 64'd0);
    check_output("wr3_c2_awvalid", 64'(bus.control_M_AXI_AWVALID), 64'd1);
    repeat (2) @(negedge clk);
    check_output("wr3_c4_awvalid", 64'(bus.control_M_AXI_AWVALID), 64'd1);
    @(negedge clk);
    check_output("wr3_c5_awvalid", 64'(bus.control_M_AXI_AWVALID), 64'd0);
    check_output("wr3_c5_bready", 64'(bus.control_M_AXI_BREADY), 64'd1);
    wait_response(start);
    check_output("wr3_b_handshakes", 64'(b_count - b_start), 64'd1);
    aw_wait = 0;

    $display("[TB] SLVERR write with stalled response consumer");
    bresp_val = 2'b10;
    bus.rsp_ready = 1'b0;
    start = rsp_count;
    apply_stimulus(1'b1, 8'h30, 32'h11223344, 4'hC, 1'b1, 32'h0, 2'b10);
    for (int n = 0; n < 50 && !bus.rsp_valid; n++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_output("wr4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check_output("wr4_rsp_resp", 64'(bus.rsp_resp), 64'h2);
      check_output("wr4_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    check_output("wr4_hs_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check_output("wr4_hs_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk); #1;
    check_output("wr4_after_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_output("wr4_after_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("wr4_rsp_seen", 64'(rsp_count - start), 64'd1);
    bresp_val = 2'b00;

    $display("[TB] zero-wait read latency");
    rdata_val = 32'hCAFEF00D; rresp_val = 2'b01;
    start = rsp_count;
    apply_stimulus(1'b0, 8'h08, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 2'b01);
    @(negedge clk);
    check_output("rd5_c1_arvalid", 64'(bus.control_M_AXI_ARVALID), 64'd1);
    @(negedge clk);
    check_output("rd5_c2_rready", 64'(bus.control_M_AXI_RREADY), 64'd1);
    @(negedge clk);
    check_output("rd5_c3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    wait_response(start);
    rresp_val = 2'b00;

`ifdef TILE_AXIL_TIMEOUT_EN
    $display("[TB] read timeout");
    ar_never = 1'b1;
    start = rsp_count;
    apply_stimulus(1'b0, 8'h0C, 32'h0, 4'h0, 1'b1, 32'h0, 2'b11);
    repeat (16) @(negedge clk);
    check_output("tmo_c16_arvalid", 64'(bus.control_M_AXI_ARVALID), 64'd1);
    @(negedge clk);
    check_output("tmo_c17_arvalid", 64'(bus.control_M_AXI_ARVALID), 64'd0);
    check_output("tmo_c17_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    wait_response(start);
    check_output("tmo_err_sticky", 64'(timeout_err), 64'd1);
    ar_never = 1'b0;
`endif

    $display("[TB] reset during read address phase");
    ar_never = 1'b1;
    apply_stimulus(1'b0, 8'h44, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
    @(negedge clk);
    check_output("rst_mid_arvalid_before", 64'(bus.control_M_AXI_ARVALID), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rst_mid_arvalid", 64'(bus.control_M_AXI_ARVALID), 64'd0);
    check_output("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ar_never = 1'b0;
    @(negedge clk);
    check_output("rst_rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_output("rst_rel_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("rst_rel_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_output("rst_rel_timeout_err", 64'(timeout_err), 64'd0);

    $display("[TB] write after reset");
    start = rsp_count;
    apply_stimulus(1'b1, 8'h3C, 32'h0BADF00D, 4'b0101, 1'b1, 32'h0, 2'b00);
    @(negedge clk);
    check_output("wr7_awaddr", 64'(bus.control_M_AXI_AWADDR), 64'h3C);
    check_output("wr7_wstrb", 64'(bus.control_M_AXI_WSTRB), 64'h5);
    wait_response(start);

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_axil_initiator.md
TILE_AXIL_INITIATOR -- requirements
Module: tile_axil_initiator

Interface
REQ-001 SHALL have parameter BW, default 32, AXI-Lite data width.
REQ-002 SHALL have parameter BWB, default BW/8, write-strobe width.
REQ-003 SHALL have parameter AXI_ADDR, default 8, AXI-Lite address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, timeout limit, used only when the timeout feature is compiled in.
REQ-005 SHALL have port clk_control, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port clk_control_rst_high, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports cmd_valid, input, 1; cmd_ready, output, 1; cmd_write, input, 1 (1=write, 0=read); cmd_addr, input, AXI_ADDR; cmd_wdata, input, BW; cmd_wstrb, input, BWB.
REQ-008 SHALL have ports rsp_valid, output, 1; rsp_ready, input, 1; rsp_rdata, output, BW; rsp_resp, output, 2.
REQ-009 SHALL have AXI-Lite master ports control_M_AXI_{AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY}, all outputs.
REQ-010 SHALL have AXI-Lite master ports control_M_AXI_{AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID}, all inputs, widths per AXI-Lite.
REQ-011 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready it SHALL capture addr/wdata/wstrb and enter WR_ADDR_DATA (cmd_write=1) or RD_ADDR (cmd_write=0).
REQ-014 In WR_ADDR_DATA, AWVALID and WVALID SHALL both assert on the first cycle in the state; each SHALL deassert the cycle after its own handshake, independently, in either order or simultaneously.
REQ-015 When both AW and W handshakes have completed, the FSM SHALL enter WR_RESP with BREADY=1; on BVALID it SHALL capture BRESP, set rsp_rdata=0, and enter RESP.
REQ-016 In RD_ADDR, ARVALID SHALL be 1; on ARREADY the FSM SHALL enter RD_DATA with RREADY=1; on RVALID it SHALL capture RDATA/RRESP and enter RESP.
REQ-017 AWADDR, ARADDR, WDATA and WSTRB SHALL be driven from captured registers and stay stable while the corresponding VALID is high; wstrb=0 SHALL pass through unchanged.
REQ-018 In RESP, rsp_valid SHALL be 1 and held with stable rsp_rdata/rsp_resp until rsp_ready, then return to IDLE; one outstanding transaction max.
REQ-019 Latency with an always-ready, zero-wait slave SHALL be: command accepted cycle 0, VALIDs cycle 1, B/R handshake cycle 2, rsp_valid cycle 3.
REQ-020 A new command SHALL NOT be accepted in the cycle that rsp_valid&rsp_ready completes (cmd_ready rises next cycle).

Reset
REQ-021 Reset SHALL asynchronously force state IDLE; all AXI VALID/READY outputs, rsp_valid, rsp_rdata, rsp_resp, addresses, data, strobes and timeout_err SHALL be 0; cmd_ready SHALL be 1.
REQ-022 Reset mid-transaction SHALL drop all VALIDs immediately and discard the transaction without any response.

Configuration
REQ-023 Macro TILE_AXIL_TIMEOUT_EN defined: a counter SHALL run from command accept until RESP entry; on reaching TIMEOUT_CYCLES it SHALL deassert all AXI VALID/READY, enter RESP with rsp_resp=2'b11, rsp_rdata=0, and set timeout_err (sticky until reset).
REQ-024 Macro TILE_AXIL_TIMEOUT_EN undefined: no counter SHALL exist, the FSM SHALL wait indefinitely, and timeout_err SHALL be tied 0.

Verification
REQ-025 Write addr 0x10, data 0xDEADBEEF, strb 0xF, zero-wait slave -> AW/W VALID cycle 1, BREADY cycle 2, rsp_valid cycle 3, rsp_resp=0, rsp_rdata=0.
REQ-026 Read addr 0x04, slave returns 0x12345678 after 5 wait cycles -> ARVALID held until ARREADY; rsp_rdata=0x12345678, rsp_resp=0.
REQ-027 Write where WREADY comes 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays high until AWREADY, single B handshake.
REQ-028 Slave BRESP=2'b10, rsp_ready held low 4 cycles -> rsp_valid and rsp_resp=2'b10 stable 4 cycles; cmd_ready=0 throughout.
REQ-029 Reset asserted while ARVALID=1 -> ARVALID=0 immediately, no rsp_valid, cmd_ready=1 after release.
REQ-030 With TILE_AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts ARREADY -> after 16 cycles ARVALID=0, rsp_resp=2'b11, timeout_err=1 until reset.
